// File: rtl/stg_mem_dp.sv
// ---------------------------------------------------------------------------
// stg_mem_dp
//
// Purpose:
//   Dual-port data-memory responder that sits behind the MA/MO pipeline pair.
//   MA presents an address on the idle port (~iw_mem_mp). That address is
//   captured and a synchronous read is launched at the same edge. In the
//   following cycle MO reads or writes through port iw_mem_mp. Because the
//   read data already waits in a hold slot, MO sees it with no added latency.
//   Both 24-bit (one word) and 48-bit (two word, addr and addr+1) accesses
//   are supported.
//
// Ports:
//   iw_clk        clock
//   iw_rst_n      asynchronous active-low reset
//   iw_mem_mp     port-phase bit from MA (MO uses port mp, MA uses ~mp)
//   iw_mem_addr0  port 0 address (valid while iw_mem_mp = 1)
//   iw_mem_addr1  port 1 address (valid while iw_mem_mp = 0)
//   iw_mo_re      MO read this cycle
//   iw_mo_we      MO write this cycle
//   iw_mo_wide    48-bit access (words addr and addr+1)
//   iw_wdata      write data, low word
//   iw_wdata_hi   write data, high word (word addr+1)
//   ow_rdata      read data, low word
//   ow_rdata_hi   read data, high word
//   ow_phase_err  sticky flag: iw_mem_mp disagreed with the internal phase
//   ow_fault      range fault (constant 0 unless MEM_RANGE_CHK_EN)
//
// Configuration:
//   MEM_RANGE_CHK_EN - when defined, an out-of-range access is a fault and
//   is not aliased or wrapped. The write is suppressed, the read returns 0
//   and ow_fault is raised. When undefined, the upper address bits alias and
//   a wide access at the last word wraps to word 0.
// ---------------------------------------------------------------------------
module stg_mem_dp #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 24,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_mem_mp,
    input  logic [ADDR_W-1:0] iw_mem_addr0,
    input  logic [ADDR_W-1:0] iw_mem_addr1,
    input  logic              iw_mo_re,
    input  logic              iw_mo_we,
    input  logic              iw_mo_wide,
    input  logic [DATA_W-1:0] iw_wdata,
    input  logic [DATA_W-1:0] iw_wdata_hi,
    output logic [DATA_W-1:0] ow_rdata,
    output logic [DATA_W-1:0] ow_rdata_hi,
    output logic              ow_phase_err,
    output logic              ow_fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    // Storage. The contents are deliberately not reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Hold slots, one per port. They are indexed by port number.
    logic [ADDR_W-1:0] addr_q  [2];
    logic [DATA_W-1:0] rdLo_q  [2];
    logic [DATA_W-1:0] rdHi_q  [2];

    logic              phase_q;
    logic              phaseErr_q;

    // Capture side (MA, idle port) and MO side (active port).
    logic              capSlot;
    logic [ADDR_W-1:0] capAddr;
    idx_t              capIdxLo;
    idx_t              capIdxHi;
    logic [ADDR_W-1:0] moAddr;
    idx_t              moIdxLo;
    idx_t              moIdxHi;
    logic              moFault;
    logic              wrLoEn;
    logic              wrHiEn;
    logic [DATA_W-1:0] rdLo_d;
    logic [DATA_W-1:0] rdHi_d;

    // Address steering. MA always drives the port MO is not using, so the
    // capture follows iw_mem_mp itself and not the internal phase tracker.
    // The +1 is done at index width, so word 4095 naturally pairs with word 0.
    always_comb begin
        capSlot  = ~iw_mem_mp;
        capAddr  = iw_mem_mp ? iw_mem_addr0 : iw_mem_addr1;
        capIdxLo = capAddr[DEPTH_LOG2-1:0];
        capIdxHi = capIdxLo + idx_t'(1);
        moAddr   = addr_q[iw_mem_mp];
        moIdxLo  = moAddr[DEPTH_LOG2-1:0];
        moIdxHi  = moIdxLo + idx_t'(1);
    end

`ifdef MEM_RANGE_CHK_EN
    // Out of range means that upper address bits are set, or that a wide
    // access starts on the last word, so its second word would need to wrap.
    always_comb begin
        moFault = (|moAddr[ADDR_W-1:DEPTH_LOG2]) || (iw_mo_wide && (&moIdxLo));
    end

    assign ow_fault = moFault && (iw_mo_re || iw_mo_we);
`else
    // Upper address bits simply alias. They and the read qualifier have no
    // effect on this build.
    logic unusedBits;

    assign moFault    = 1'b0;
    assign ow_fault   = 1'b0;
    assign unusedBits = ^{moAddr[ADDR_W-1:DEPTH_LOG2], iw_mo_re};
`endif

    // A faulting write is dropped completely, including both words of a wide
    // write.
    assign wrLoEn = iw_mo_we && !moFault;
    assign wrHiEn = wrLoEn && iw_mo_wide;

    // Write-first bypass. If the edge that performs MO's write also captures
    // one of the written words, the slot takes the new data and not the stale
    // array word.
    always_comb begin
        rdLo_d = mem_q[capIdxLo];
        rdHi_d = mem_q[capIdxHi];
        if (wrLoEn && (capIdxLo == moIdxLo)) begin
            rdLo_d = iw_wdata;
        end else if (wrHiEn && (capIdxLo == moIdxHi)) begin
            rdLo_d = iw_wdata_hi;
        end
        if (wrLoEn && (capIdxHi == moIdxLo)) begin
            rdHi_d = iw_wdata;
        end else if (wrHiEn && (capIdxHi == moIdxHi)) begin
            rdHi_d = iw_wdata_hi;
        end
    end

    // Array write. Sampling reset at the edge drops a write whose cycle was
    // cut short by reset.
    always_ff @(posedge iw_clk) begin
        if (iw_rst_n && wrLoEn) begin
            mem_q[moIdxLo] <= iw_wdata;
        end
        if (iw_rst_n && wrHiEn) begin
            mem_q[moIdxHi] <= iw_wdata_hi;
        end
    end

    // Capture of the address and read data into the idle port's slot.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                addr_q[i] <= '0;
                rdLo_q[i] <= '0;
                rdHi_q[i] <= '0;
            end
        end else begin
            addr_q[capSlot] <= capAddr;
            rdLo_q[capSlot] <= rdLo_d;
            rdHi_q[capSlot] <= rdHi_d;
        end
    end

    // The phase tracker toggles every cycle. Any disagreement with MA's phase
    // bit latches an error that only reset clears.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            phase_q    <= 1'b0;
            phaseErr_q <= 1'b0;
        end else begin
            phase_q    <= ~phase_q;
            phaseErr_q <= phaseErr_q | (iw_mem_mp != phase_q);
        end
    end

    // MO read data comes straight from its slot. The outputs are driven
    // whether or not a read is requested. A faulting read shows zero.
    always_comb begin
        ow_rdata    = rdLo_q[iw_mem_mp];
        ow_rdata_hi = rdHi_q[iw_mem_mp];
        if (moFault && iw_mo_re) begin
            ow_rdata    = '0;
            ow_rdata_hi = '0;
        end
    end

    assign ow_phase_err = phaseErr_q;

endmodule

// File: doc/stg_mem_dp.md
Name: stg_mem_dp

Overview:
- Dual-port data-memory responder serving the MA/MO pipeline pair.
- Captures the address MA drives on the idle port (index ~iw_mem_mp) and starts a synchronous read at that edge.
- Next cycle it serves MO's read or write on port iw_mem_mp, so MO sees read data with zero added latency.
- Supports 24-bit and 48-bit (two-word) accesses.

Parameters:
- DATA_W, 24, word width (`SIZE_DATA).
- ADDR_W, 24, address width (`SIZE_ADDR).
- DEPTH_LOG2, 12, log2 of the storage depth in words (4096).

Ports:
- iw_clk  in  1  clock.
- iw_rst_n  in  1  reset; asynchronous, active-low.
- iw_mem_mp  in  1  port-phase bit from MA; MO uses port mp and MA drives port ~mp.
- iw_mem_addr0  in  ADDR_W  port 0 address; valid only when iw_mem_mp=1.
- iw_mem_addr1  in  ADDR_W  port 1 address; valid only when iw_mem_mp=0.
- iw_mo_re  in  1  MO read this cycle.
- iw_mo_we  in  1  MO write this cycle.
- iw_mo_wide  in  1  48-bit access: words addr and addr+1.
- iw_wdata  in  DATA_W  write data, low word.
- iw_wdata_hi  in  DATA_W  write data, high word (word addr+1).
- ow_rdata  out  DATA_W  read data, low word.
- ow_rdata_hi  out  DATA_W  read data, high word.
- ow_phase_err  out  1  sticky flag: iw_mem_mp disagrees with the internal phase.
- ow_fault  out  1  range fault; present only with the optional feature, otherwise tied 0.

Behaviour:
- Storage: mem[2^DEPTH_LOG2] of DATA_W. Contents are not reset.
- Index = addr[DEPTH_LOG2-1:0]. Upper address bits alias unless the optional feature is enabled.
- Hold slots r_addr[0:1] and r_rd_lo[0:1], r_rd_hi[0:1]. Let s = ~iw_mem_mp.
- At each posedge (not in reset):
  - r_addr[s] <= iw_mem_addr_s.
  - r_rd_lo[s] <= mem[idx(addr)].
  - r_rd_hi[s] <= mem[idx(addr)+1], with index wrap mod 2^DEPTH_LOG2 (word 4095 pairs with word 0).
- MO cycle, p = iw_mem_mp:
  - ow_rdata = r_rd_lo[p] and ow_rdata_hi = r_rd_hi[p], combinational from the slots.
  - Outputs are driven regardless of iw_mo_re; iw_mo_re is only qualifying and gates ow_fault.
- Write, iw_mo_we=1:
  - At the cycle-end edge, mem[idx(r_addr[p])] <= iw_wdata.
  - If iw_mo_wide=1, also mem[idx(r_addr[p])+1] <= iw_wdata_hi, with the same wrap.
  - Wide write at index 4095 writes 4095 and 0.
- Read-during-write at the same edge (write-first bypass): if the captured read index (lo or hi) equals a written index, the slot loads the new write data, not stale memory.
- iw_mo_re and iw_mo_we both high: the write is performed and the outputs show the pre-write data.
- Phase tracker:
  - r_phase resets to 0 and toggles every cycle.
  - If iw_mem_mp != r_phase in any cycle, ow_phase_err sets at the next edge and stays set until reset.
  - Address capture keeps following iw_mem_mp, not r_phase.
- Reset, iw_rst_n=0 asynchronously clears: r_addr, r_rd_*, r_phase, ow_phase_err, ow_fault. Hence ow_rdata=ow_rdata_hi=0.
  - The first MO cycle after release reads 0 (slot 0 is the reset value), not mem[0].
- Reset asserted mid-write: the write in progress is dropped if reset is asserted before its edge.

Optional Feature:
- Macro: MEM_RANGE_CHK_EN.
- When defined:
  - An access with addr >= 2^DEPTH_LOG2, or a wide access whose addr+1 exceeds the range, is a fault. No wrap is allowed when checking.
  - On a fault, a write is suppressed entirely, both words.
  - On a fault, a read returns 0 on ow_rdata and ow_rdata_hi.
  - ow_fault is high combinationally in that MO cycle when iw_mo_re or iw_mo_we is high.
- When undefined: upper bits alias, wide accesses wrap, and ow_fault is constant 0.

Test Plan:
- Write then read:
  - Cycle A: MA addr 0x000010 on port ~mp; next cycle iw_mo_we=1, wdata 0xABCDEF.
  - Later: MA addr 0x10, then iw_mo_re → ow_rdata=0xABCDEF in the same MO cycle.
- Wide wrap:
  - Wide write at 0x000FFF with lo 0x111111, hi 0x222222.
  - Wide read of 0xFFF → ow_rdata=0x111111, ow_rdata_hi=0x222222; mem[0]=0x222222.
- Bypass:
  - MO writes 0x5A5A5A to 0x20 while MA simultaneously presents 0x20.
  - Next cycle ow_rdata=0x5A5A5A.
- Phase error:
  - Hold iw_mem_mp constant for two cycles after reset → ow_phase_err=1 and remains 1.
  - Assert iw_rst_n=0 → ow_phase_err=0 immediately (async).
- Reset:
  - Pulse iw_rst_n low mid-run → ow_rdata=0 and ow_rdata_hi=0 at once.
  - First post-reset MO read returns 0.
- Range check, MEM_RANGE_CHK_EN defined:
  - Write to 0x001000 → ow_fault=1, memory unchanged.
  - Read of 0x000000 afterwards returns its prior value.
